bp_cce_pending_counter_table: RTL and testbench
===============================================

# bp_cce_pending_counter_table

Per-way-group pending-transaction counter table inside the CCE. Accepts increment, decrement and clear requests from the CCE instruction decode/execute stage, and answers registered "is this way group pending" lookups for the read stage. It also drives a registered write-trace stream (valid, way group, new counter value) that feeds directly into the nonsynthesizable CCE pending tracer.

## Interface
Parameters:
- num_way_groups_p, 64, number of way groups (entries); power of two, ≥2
- width_p, 3, counter width per entry
- lg_num_way_groups_lp, clog2(num_way_groups_p), local, way-group index width
- lg_count_lp, clog2(num_way_groups_p+1), local, width of the busy-entry count

Ports:
- clk_i  in  1  clock, all state updates on posedge
- reset_i  in  1  reset; asynchronous, active-low
- w_v_i  in  1  write request valid
- w_wg_i  in  lg_num_way_groups_lp  write way group
- w_pending_i  in  1  1 = increment, 0 = decrement
- w_clear_i  in  1  force the entry to 0; overrides w_pending_i
- r_v_i  in  1  read request valid
- r_wg_i  in  lg_num_way_groups_lp  read way group
- r_v_o  out  1  read response valid
- r_pending_o  out  1  entry is non-zero
- r_count_o  out  width_p  entry value
- busy_count_o  out  lg_count_lp  number of non-zero entries
- overflow_o  out  1  sticky: increment was attempted at max
- underflow_o  out  1  sticky: decrement was attempted at 0
- trace_v_o  out  1  write-trace valid
- trace_wg_o  out  lg_num_way_groups_lp  write-trace way group
- trace_val_o  out  width_p  write-trace value, the new value of the entry

## Operation
- Storage: num_way_groups_p × width_p flops. Every entry is cleared by reset.
- Write, when w_v_i=1. Let old = entry[w_wg_i].
  - w_clear_i=1: new = 0.
  - w_pending_i=1: new = old+1. If old = 2^width_p−1, new = old (saturate) and overflow_o is set.
  - w_pending_i=0: new = old−1. If old = 0, new = 0 and underflow_o is set.
- overflow_o and underflow_o stay set until reset.
- busy_count_o is maintained incrementally:
  - +1 when old=0 and new≠0.
  - −1 when old≠0 and new=0.
  - Otherwise unchanged.
  - It must always equal the population of non-zero entries.
- Read, when r_v_i=1:
  - The response is registered.
  - If the write in the same cycle targets the same way group (w_v_i=1, w_wg_i=r_wg_i), the response reflects the new value (bypass).
  - When r_v_i=0, r_v_o=0, and r_pending_o and r_count_o hold their previous values.
- Trace: every accepted write produces exactly one trace beat carrying w_wg and the new value. This includes saturated writes (value unchanged) and clears of entries already at 0.
- At most one write and one read per cycle. There is no backpressure; both requests are always accepted.

## Timing
- Write issued in cycle N:
  - The entry, busy_count_o, overflow_o and underflow_o update at the posedge ending cycle N.
  - trace_v_o/trace_wg_o/trace_val_o are valid during cycle N+1.
  - trace_v_o is a single-cycle pulse per write.
- Read issued in cycle N: r_v_o, r_pending_o and r_count_o are valid during cycle N+1. This is 1-cycle latency, and the response includes cycle N's write to the same way group.
- Back-to-back writes to the same way group in cycles N and N+1 chain correctly: N+1 sees N's result.
- Reset asserted (reset_i=0), immediately and asynchronously, including mid-stream:
  - All entries are 0.
  - r_v_o, r_pending_o, r_count_o are 0.
  - busy_count_o is 0.
  - overflow_o and underflow_o are 0.
  - trace_v_o, trace_wg_o, trace_val_o are 0.
- Requests presented while reset_i=0 are dropped.
- The first accepted request is in the first posedge after reset_i rises.

## Test plan
- Reset check: after reset, read every way group 0..63 → r_pending_o=0 and r_count_o=0 each cycle; busy_count_o=0; no trace beats.
- Increment and decrement, wg 5: three increments in cycles 1–3 then two decrements.
  - Trace values 1,2,3,2,1.
  - busy_count_o: 1 after the first increment, still 1 at the end.
  - A read of wg 5 returns count 1, pending 1.
- Saturate at max, width_p=3, wg 9: eight increments.
  - Counter stops at 7.
  - overflow_o rises at the 8th write and stays set.
  - The 8th trace beat shows 7.
- Floor at zero, wg 2 (empty): one decrement → trace beat (2,0), underflow_o=1, busy_count_o stays 0.
- Clear with a simultaneous read, wg 12 holding 4: in one cycle issue clear on wg 12 and read of wg 12.
  - Next cycle: r_v_o=1, r_count_o=0, r_pending_o=0.
  - busy_count_o decrements by 1.
- Mid-operation reset: 10 entries non-zero, then reset_i is pulsed low between clock edges.
  - All outputs are 0 immediately, before the next clock edge.
  - A read of any of the 10 entries after reset returns 0.

Source files
------------

// File: rtl/bp_cce_pending_counter_table.sv
`default_nettype none
// ============================================================================
//  Module   : bp_cce_pending_counter_table
//  Purpose  : Per-way-group saturating pending-transaction counters for the
//             CCE. Provides inc/dec/clear writes, registered lookups with
//             same-cycle write bypass, a live busy-entry count, sticky
//             overflow/underflow flags and a registered write-trace stream.
//  Revision : 1.0 - initial release
// ============================================================================
module bp_cce_pending_counter_table #(
  parameter  int num_way_groups_p     = 64,
  parameter  int width_p              = 3,
  localparam int lg_num_way_groups_lp = $clog2(num_way_groups_p),
  localparam int lg_count_lp          = $clog2(num_way_groups_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  logic                            w_v_i,
  input  logic [lg_num_way_groups_lp-1:0] w_wg_i,
  input  logic                            w_pending_i,
  input  logic                            w_clear_i,

  input  logic                            r_v_i,
  input  logic [lg_num_way_groups_lp-1:0] r_wg_i,

  output logic                            r_v_o,
  output logic                            r_pending_o,
  output logic [width_p-1:0]              r_count_o,

  output logic [lg_count_lp-1:0]          busy_count_o,
  output logic                            overflow_o,
  output logic                            underflow_o,

  output logic                            trace_v_o,
  output logic [lg_num_way_groups_lp-1:0] trace_wg_o,
  output logic [width_p-1:0]              trace_val_o
);

  localparam logic [width_p-1:0]     cnt_max_lp  = '1;
  localparam logic [width_p-1:0]     cnt_one_lp  = width_p'(1);
  localparam logic [lg_count_lp-1:0] busy_one_lp = lg_count_lp'(1);

  // Counter storage, one register per way group
  logic [width_p-1:0] mem_q [num_way_groups_p];

  // Write datapath
  logic [width_p-1:0] old_val;
  logic [width_p-1:0] new_val;
  logic               ovf_hit;
  logic               unf_hit;

  // Read datapath
  logic [width_p-1:0] rd_val;

  // Next-state of the aggregate status registers
  logic [lg_count_lp-1:0] busy_count_d, busy_count_q;
  logic                   overflow_d,   overflow_q;
  logic                   underflow_d,  underflow_q;

  // Read response and trace registers
  logic                            r_v_q;
  logic                            r_pending_q;
  logic [width_p-1:0]              r_count_q;
  logic                            trace_v_q;
  logic [lg_num_way_groups_lp-1:0] trace_wg_q;
  logic [width_p-1:0]              trace_val_q;

  assign old_val = mem_q[w_wg_i];

  // New counter value for the addressed entry; saturates at both ends
  always_comb begin
    new_val = old_val;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    if (w_clear_i) begin
      new_val = '0;
    end else if (w_pending_i) begin
      if (old_val == cnt_max_lp) ovf_hit = 1'b1;
      else                       new_val = old_val + cnt_one_lp;
    end else begin
      if (old_val == '0) unf_hit = 1'b1;
      else               new_val = old_val - cnt_one_lp;
    end
  end

  // Busy count tracks zero/non-zero transitions of the written entry; sticky flags accumulate
  always_comb begin
    busy_count_d = busy_count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (w_v_i) begin
      if ((old_val == '0) && (new_val != '0))      busy_count_d = busy_count_q + busy_one_lp;
      else if ((old_val != '0) && (new_val == '0)) busy_count_d = busy_count_q - busy_one_lp;
      overflow_d  = overflow_q  | ovf_hit;
      underflow_d = underflow_q | unf_hit;
    end
  end

  // A same-cycle write to the read way group is forwarded into the response
  assign rd_val = (w_v_i && (w_wg_i == r_wg_i)) ? new_val : mem_q[r_wg_i];

  generate
    for (genvar g = 0; g < num_way_groups_p; g++) begin : g_entry
      // Entry register: updated only when the write addresses this way group
      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          mem_q[g] <= '0;
        end else if (w_v_i && (w_wg_i == lg_num_way_groups_lp'(g))) begin
          mem_q[g] <= new_val;
        end
      end
    end
  endgenerate

  // Aggregate status registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_count_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      busy_count_q <= busy_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Read response: valid pulses per request, data holds when idle
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_v_q       <= 1'b0;
      r_pending_q <= 1'b0;
      r_count_q   <= '0;
    end else begin
      r_v_q <= r_v_i;
      if (r_v_i) begin
        r_pending_q <= |rd_val;
        r_count_q   <= rd_val;
      end
    end
  end

  // Write trace: one beat per accepted write, carrying the entry's new value
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      trace_v_q   <= 1'b0;
      trace_wg_q  <= '0;
      trace_val_q <= '0;
    end else begin
      trace_v_q <= w_v_i;
      if (w_v_i) begin
        trace_wg_q  <= w_wg_i;
        trace_val_q <= new_val;
      end
    end
  end

  assign r_v_o        = r_v_q;
  assign r_pending_o  = r_pending_q;
  assign r_count_o    = r_count_q;
  assign busy_count_o = busy_count_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;
  assign trace_v_o    = trace_v_q;
  assign trace_wg_o   = trace_wg_q;
  assign trace_val_o  = trace_val_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_pending_counter_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_cce_pending_counter_table
//  Purpose  : Self-checking bench for bp_cce_pending_counter_table
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_cce_pending_counter_table;

  localparam int NWG = 64;
  localparam int W   = 3;
  localparam int LGW = $clog2(NWG);
  localparam int LGC = $clog2(NWG + 1);

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           w_v_i, w_pending_i, w_clear_i, r_v_i;
  logic [LGW-1:0] w_wg_i, r_wg_i;
  logic           r_v_o, r_pending_o, overflow_o, underflow_o, trace_v_o;
  logic [W-1:0]   r_count_o, trace_val_o;
  logic [LGC-1:0] busy_count_o;
  logic [LGW-1:0] trace_wg_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bp_cce_pending_counter_table #(.num_way_groups_p(NWG), .width_p(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .w_v_i(w_v_i), .w_wg_i(w_wg_i), .w_pending_i(w_pending_i), .w_clear_i(w_clear_i),
    .r_v_i(r_v_i), .r_wg_i(r_wg_i),
    .r_v_o(r_v_o), .r_pending_o(r_pending_o), .r_count_o(r_count_o),
    .busy_count_o(busy_count_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .trace_v_o(trace_v_o), .trace_wg_o(trace_wg_o), .trace_val_o(trace_val_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic     w_v;
    int       wg;
    logic     pend;
    logic     clr;
    logic     r_v;
    int       rwg;
    int       tval;
    int       rcnt;
    int       busy;
    int       ovf;
    int       unf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w_v, input int wg, input logic pend, input logic clr,
                              input logic r_v, input int rwg, input int tval, input int rcnt,
                              input int busy, input int ovf, input int unf);
    vec_t v;
    v.w_v = w_v; v.wg = wg; v.pend = pend; v.clr = clr; v.r_v = r_v; v.rwg = rwg;
    v.tval = tval; v.rcnt = rcnt; v.busy = busy; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic drive(input logic w_v, input int wg, input logic pend, input logic clr,
                       input logic r_v, input int rwg);
    w_v_i = w_v; w_wg_i = LGW'(wg); w_pending_i = pend; w_clear_i = clr;
    r_v_i = r_v; r_wg_i = LGW'(rwg);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " r_v"},       int'(r_v_o),        0);
    chk({tag, " r_pending"}, int'(r_pending_o),  0);
    chk({tag, " r_count"},   int'(r_count_o),    0);
    chk({tag, " busy"},      int'(busy_count_o), 0);
    chk({tag, " ovf"},       int'(overflow_o),   0);
    chk({tag, " unf"},       int'(underflow_o),  0);
    chk({tag, " trace_v"},   int'(trace_v_o),    0);
    chk({tag, " trace_wg"},  int'(trace_wg_o),   0);
    chk({tag, " trace_val"}, int'(trace_val_o),  0);
  endtask

  initial begin
    int   last_rcnt;
    vec_t e;
    last_rcnt = 0;

    // ---------------- reset ----------------
    reset_i = 1'b0;
    drive(1'b1, 7, 1'b1, 1'b0, 1'b0, 0);   // dropped while in reset
    repeat (3) cyc();
    chk_all_zero("in_reset");
    @(negedge clk_i);
    reset_i = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < NWG; i++) begin
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1, i);
      cyc();
      chk("rst_read r_v", int'(r_v_o), 1);
      chk("rst_read pending", int'(r_pending_o), 0);
      chk("rst_read count", int'(r_count_o), 0);
      chk("rst_read busy", int'(busy_count_o), 0);
      chk("rst_read trace_v", int'(trace_v_o), 0);
    end

    // ---------------- vector table ----------------
    //            w_v wg pend clr  r_v rwg tval rcnt busy ovf unf
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 3, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 0, 1, 1, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 9, 1, 0, 0, 0, (k > 7) ? 7 : k, 0, 2, (k == 8) ? 1 : 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 9, 0, 7, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 2, 1, 0));   // idle: read data holds
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 2, 1, 1));   // floor at zero
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(1, 12, 1, 0, 0, 0, k, 0, 3, 1, 1));
    vecs.push_back(mk(1, 12, 1, 1, 1, 12, 0, 0, 2, 1, 1)); // clear overrides pend, bypass read
    vecs.push_back(mk(1, 20, 0, 1, 0, 0, 0, 0, 2, 1, 1));  // clear of empty entry
    vecs.push_back(mk(1, 5, 1, 0, 1, 5, 2, 2, 2, 1, 1));   // inc with bypass read
    vecs.push_back(mk(1, 9, 0, 0, 1, 5, 6, 2, 2, 1, 1));   // different wg: no bypass

    foreach (vecs[i]) begin
      drive(vecs[i].w_v, vecs[i].wg, vecs[i].pend, vecs[i].clr, vecs[i].r_v, vecs[i].rwg);
      sb.push_back(vecs[i]);
      cyc();
      e = sb.pop_front();
      chk($sformatf("v%0d trace_v", i), int'(trace_v_o), int'(e.w_v));
      if (e.w_v) begin
        chk($sformatf("v%0d trace_wg", i),  int'(trace_wg_o),  e.wg);
        chk($sformatf("v%0d trace_val", i), int'(trace_val_o), e.tval);
      end
      chk($sformatf("v%0d r_v", i), int'(r_v_o), int'(e.r_v));
      if (e.r_v) last_rcnt = e.rcnt;
      chk($sformatf("v%0d r_count", i),   int'(r_count_o),   last_rcnt);
      chk($sformatf("v%0d r_pending", i), int'(r_pending_o), (last_rcnt != 0) ? 1 : 0);
      chk($sformatf("v%0d busy", i),      int'(busy_count_o), e.busy);
      chk($sformatf("v%0d ovf", i),       int'(overflow_o),   e.ovf);
      chk($sformatf("v%0d unf", i),       int'(underflow_o),  e.unf);
    end

    // ---------------- mid-operation asynchronous reset ----------------
    for (int i = 30; i < 40; i++) begin
      drive(1'b1, i, 1'b1, 1'b0, 1'b1, i);
      cyc();
    end
    chk("pre_rst busy", int'(busy_count_o), 12);
    chk("pre_rst trace_v", int'(trace_v_o), 1);
    drive(1'b1, 33, 1'b1, 1'b0, 1'b1, 33);
    #2;
    reset_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2;
    reset_i = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 30; i < 40; i++) begin
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1, i);
      cyc();
      chk($sformatf("post_rst wg%0d count", i), int'(r_count_o), 0);
      chk($sformatf("post_rst wg%0d pending", i), int'(r_pending_o), 0);
    end
    chk("post_rst busy", int'(busy_count_o), 0);
    chk("post_rst ovf", int'(overflow_o), 0);
    chk("post_rst unf", int'(underflow_o), 0);

    // first write after reset starts from zero
    drive(1'b1, 9, 1'b1, 1'b0, 1'b0, 0);
    cyc();
    chk("post_rst inc9 trace_val", int'(trace_val_o), 1);
    chk("post_rst inc9 busy", int'(busy_count_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
